// File: rtl/tri_seq_checker.sv
// Locks onto a 0..MAX..0 triangle count stream, predicts each next sample, flags deviations,
// counts completed periods and mismatches. Optional CHK_STICKY_ERR_EN makes err sticky until err_clr.
module tri_seq_checker #(
  parameter int unsigned W   = 3,
  parameter int unsigned MAX = 5,
  parameter int unsigned CW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [W-1:0]  count_in,
  input  logic          err_clr,
  output logic          locked,
  output logic [W-1:0]  expected,
  output logic          err,
  output logic [CW-1:0] period_cnt,
  output logic [CW-1:0] err_cnt
);

  localparam logic [W-1:0] MaxVal = W'(MAX);
  localparam logic [W-1:0] Zero   = '0;
  localparam logic [W-1:0] One    = W'(1);

  typedef enum logic [1:0] {StSearch, StArm, StTrack} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   m_cnt_q, m_cnt_d;
  logic           m_dir_q, m_dir_d;

  logic [W-1:0]   pred;
  logic           pred_dir;
  logic           match;
  logic           track_sample;
  logic           mismatch;
  logic           period_inc;

  logic           locked_d;
  logic [W-1:0]   expected_d;
  logic           err_d;
  logic [CW-1:0]  period_cnt_d;
  logic [CW-1:0]  err_cnt_d;

  // Next count of the mirrored up/down counter; turnaround values are held for one sample.
  function automatic logic [W-1:0] step_cnt(input logic [W-1:0] cnt, input logic dir);
    logic [W-1:0] nxt;
    nxt = cnt;
    if (dir) begin
      if (cnt < MaxVal) nxt = cnt + One;
    end else begin
      if (cnt > Zero) nxt = cnt - One;
    end
    return nxt;
  endfunction

  function automatic logic step_dir(input logic [W-1:0] cnt, input logic dir);
    logic nxt;
    nxt = dir;
    if (dir && (cnt == MaxVal)) nxt = 1'b0;
    if (!dir && (cnt == Zero))  nxt = 1'b1;
    return nxt;
  endfunction

  always_comb begin
    pred         = step_cnt(m_cnt_q, m_dir_q);
    pred_dir     = step_dir(m_cnt_q, m_dir_q);
    match        = (count_in == pred);
    track_sample = en && (state_q == StTrack);
    mismatch     = track_sample && !match;
    // A period closes when the model leaves the bottom hold (0, down) for (0, up).
    period_inc   = track_sample && match && (m_cnt_q == Zero) && !m_dir_q;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StSearch;
      m_cnt_q <= '0;
      m_dir_q <= 1'b1;
    end else begin
      state_q <= state_d;
      m_cnt_q <= m_cnt_d;
      m_dir_q <= m_dir_d;
    end
  end

  // Next-state and model update
  always_comb begin
    state_d = state_q;
    m_cnt_d = m_cnt_q;
    m_dir_d = m_dir_q;
    if (en) begin
      case (state_q)
        StSearch: begin
          if (count_in == Zero) state_d = StArm;
        end
        StArm: begin
          if (count_in == One) begin
            state_d = StTrack;
            m_cnt_d = One;
            m_dir_d = 1'b1;
          end else if (count_in != Zero) begin
            state_d = StSearch;
          end
        end
        StTrack: begin
          if (match) begin
            m_cnt_d = pred;
            m_dir_d = pred_dir;
          end else begin
            state_d = (count_in == Zero) ? StArm : StSearch;
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  // Output next values; every output is registered below.
  always_comb begin
    locked_d     = (state_d == StTrack);
    expected_d   = locked_d ? step_cnt(m_cnt_d, m_dir_d) : Zero;
    period_cnt_d = period_inc ? period_cnt + CW'(1) : period_cnt;
    err_cnt_d    = (mismatch && (err_cnt != {CW{1'b1}})) ? err_cnt + CW'(1) : err_cnt;
`ifdef CHK_STICKY_ERR_EN
    // Set wins over a simultaneous clear; clear is honoured regardless of en.
    if (mismatch)     err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err;
`else
    err_d        = mismatch;
`endif
  end

`ifndef CHK_STICKY_ERR_EN
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked     <= 1'b0;
      expected   <= '0;
      err        <= 1'b0;
      period_cnt <= '0;
      err_cnt    <= '0;
    end else begin
      locked     <= locked_d;
      expected   <= expected_d;
      err        <= err_d;
      period_cnt <= period_cnt_d;
      err_cnt    <= err_cnt_d;
    end
  end

endmodule

// File: doc/tri_seq_checker.md
# tri_seq_checker

- Monitors the 3-bit triangle count stream produced by the up/down counter stage (0→MAX→0 with one-cycle hold at each turnaround).
- Sits directly downstream of that counter and locks onto the stream.
- Predicts every next value, flags deviations, counts completed periods and accumulates an error count for status/debug logic.

## Interface
- W, 3: width of the count input and of `expected`.
- MAX, 5: turnaround value of the upstream counter; must be < 2^W.
- CW, 8: width of `period_cnt` and `err_cnt`.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all state.
- en  input  1  sample enable; the input is evaluated only on edges where en=1.
- count_in  input  W  count value from the upstream counter.
- err_clr  input  1  clears the sticky error flag; ignored unless CHK_STICKY_ERR_EN is defined.
- locked  output  1  high while in TRACK.
- expected  output  W  predicted value of the next sample; 0 when not in TRACK.
- err  output  1  mismatch indication; pulse or sticky, see Configuration.
- period_cnt  output  CW  number of completed periods; wraps modulo 2^CW.
- err_cnt  output  CW  number of mismatches; saturates at 2^CW-1.

## Operation
**Model**
- Internal registers `m_cnt` (W bits) and `m_dir` (1 bit) mirror the upstream counter.
- Prediction `pred` and the next model value follow these rules:
  - dir=1 and cnt<MAX: cnt+1.
  - dir=1 and cnt=MAX: hold cnt, dir→0.
  - dir=0 and cnt>0: cnt−1.
  - dir=0 and cnt=0: hold cnt, dir→1.
- One full period is 2·MAX+2 samples: 0,1,2,3,4,5,5,4,3,2,1,0 for MAX=5.

**States** (all transitions occur only on edges with en=1)
- SEARCH (reset state):
  - count_in=0 → ARM.
  - Any other value → stay in SEARCH.
- ARM:
  - count_in=1 → TRACK, with m_cnt=1, m_dir=1.
  - count_in=0 → stay in ARM.
  - Any other value → SEARCH.
- TRACK, when count_in=pred:
  - Advance the model.
  - If the advance is the (0,dir=0)→(0,dir=1) turnaround, increment period_cnt.
- TRACK, when count_in≠pred (includes out-of-range values >MAX):
  - Assert err and increment err_cnt (saturating).
  - Next state is ARM if count_in=0, otherwise SEARCH.
- No mismatch is ever reported in SEARCH or ARM.

**Other rules**
- en=0: state, model and counters hold; err pulse deasserts.
- Reset mid-operation: immediate return to SEARCH with all outputs at their reset values; period_cnt and err_cnt are lost.

## Timing
- All outputs are registered.
- Reset values: locked=0, expected=0, err=0, period_cnt=0, err_cnt=0.
- The sample is evaluated at edge N; its effects (err, err_cnt, period_cnt, locked, expected) are visible after edge N. Latency is 1 cycle.
- locked rises after the edge that accepts the sample 1 in ARM.
- expected is combinational-free: it is registered `pred` of the updated model and is valid whenever locked=1.
- Non-sticky mode: err is high for exactly one cycle per mismatch. It stays high on consecutive cycles only if consecutive mismatching samples occur.
- Mismatch and a period increment cannot coincide, because a period increment requires a match.

## Configuration
- Macro: CHK_STICKY_ERR_EN.
- Defined:
  - err sets on the first mismatch and stays high until err_clr=1 is sampled on an edge (err_clr is evaluated independently of en).
  - If a mismatch and err_clr occur on the same edge, err remains 1 (set wins).
  - err_cnt behaviour is unchanged.
- Undefined:
  - err is a one-cycle pulse per mismatch.
  - err_clr has no effect and may be tied low.

## Test plan
- Reset check: assert rst asynchronously mid-cycle → all outputs 0 immediately; locked stays 0 for count_in held at 3.
- Lock and periods: after reset, drive the ideal stream 0,1,2,3,4,5,5,4,3,2,1,0,0,1,… with en=1 → locked=1 after the sample 1, expected=2, period_cnt=1 after the second 0 following the 1,0 turnaround, err never asserts over 10 periods, period_cnt=10.
- Mismatch: while locked, drive 2,3,5 (skip 4) → err pulse one cycle, err_cnt=1, locked=0; then 0,1 → locked=1 again.
- Enable gating: while locked at 3 (expected=4), hold en=0 for 5 cycles with count_in=7 → no err, expected stays 4; resume with 4 → no error.
- Saturation and reset mid-TRACK: CW=4, inject 20 mismatches → err_cnt=15; assert rst during TRACK → err_cnt=0, locked=0.
- Sticky build (CHK_STICKY_ERR_EN): one mismatch → err stays 1 across 20 cycles of correct stream; err_clr pulse → err=0 next cycle; mismatch coinciding with err_clr → err=1.
